// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the cv32e40p fault-tolerant execution units.
// Holds the TMR mode encoding and the helpers that derive it from the fault vector.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        TMR_FULL     = 2'b00,
        TMR_DEGRADED = 2'b01,
        TMR_FAILED   = 2'b10
    } tmr_mode_e;

    localparam int unsigned TMR_THRESHOLD_DEFAULT = 32'd100;
    localparam int unsigned TMR_LEAK_DEFAULT      = 32'd2;

    function automatic logic [1:0] tmr_popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic tmr_mode_e tmr_mode_decode(input logic [2:0] faulty);
        tmr_mode_e m;
        case (tmr_popcount3(faulty))
            2'd0:    m = TMR_FULL;
            2'd1:    m = TMR_DEGRADED;
            default: m = TMR_FAILED;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_err_counter.sv
// Leaky-bucket error counter for one TMR replica with a sticky fault latch.
// Once latched faulty the counter is frozen until clear_i or reset.
module cv32e40p_tmr_err_counter #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned THRESHOLD = 100,
    parameter int unsigned LEAK      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             update_i,
    input  logic             mism_i,
    output logic [CNT_W-1:0] count_o,
    output logic             faulty_o,
    output logic             event_o
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             r_faulty;
    logic             r_event;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cross;

    // Saturating increment on mismatch, floor-at-zero leak otherwise
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_cross   = 1'b0;
        if (update_i && !r_faulty) begin
            if (mism_i) begin
                if (r_cnt != LP_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end else begin
                if (32'(r_cnt) >= LEAK) begin
                    w_cnt_nxt = r_cnt - CNT_W'(LEAK);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            w_cross = (32'(w_cnt_nxt) >= THRESHOLD);
        end else begin
            w_cnt_nxt = r_cnt;
            w_cross   = 1'b0;
        end
    end

    // Counter, sticky fault flag and single-cycle rise event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_faulty <= 1'b0;
            r_event  <= 1'b0;
        end else if (clear_i) begin
            r_cnt    <= '0;
            r_faulty <= 1'b0;
            r_event  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_faulty <= r_faulty | w_cross;
            r_event  <= w_cross;
        end
    end

    assign count_o  = r_cnt;
    assign faulty_o = r_faulty;
    assign event_o  = r_event;

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR voter with per-replica permanent-fault tracking; degrades from full TMR
// to duplex to failed as replicas are latched faulty.
module cv32e40p_tmr_fault_monitor
    import cv32e40p_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned THRESHOLD = TMR_THRESHOLD_DEFAULT,
    parameter int unsigned LEAK      = TMR_LEAK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            enable_i,
    input  logic [2:0][WIDTH-1:0] data_i,
    input  logic                  clear_i,
    output logic [WIDTH-1:0]      voted_o,
    output logic                  err_detected_o,
    output logic                  err_corrected_o,
    output logic                  err_uncorrectable_o,
    output logic [2:0]            faulty_o,
    output logic [2:0]            perf_event_o,
    output tmr_mode_e             mode_o,
    output logic [2:0][CNT_W-1:0] count_o
);

    if ((THRESHOLD < 32'd1) || (THRESHOLD > ((32'd1 << CNT_W) - 32'd1))) begin : g_thr_check
        $fatal(1, "cv32e40p_tmr_fault_monitor: THRESHOLD must lie in 1..2^CNT_W-1");
    end

    logic [WIDTH-1:0]      w_maj;
    logic [WIDTH-1:0]      w_lo;
    logic [WIDTH-1:0]      w_hi;
    logic [WIDTH-1:0]      w_voted;
    logic [2:0]            w_faulty;
    logic [2:0]            w_event;
    logic [2:0]            w_mism;
    logic [2:0]            w_update;
    logic [2:0][CNT_W-1:0] w_count;
    logic                  w_det;
    logic                  w_cor;
    logic                  w_unc;
    tmr_mode_e             w_mode;

    assign w_maj  = (data_i[0] & data_i[1]) | (data_i[0] & data_i[2]) | (data_i[1] & data_i[2]);
    assign w_mode = tmr_mode_decode(w_faulty);

    // Lowest healthy replica (a) and the second healthy one (b) for duplex mode
    always_comb begin
        w_lo = data_i[0];
        if (!w_faulty[0]) begin
            w_lo = data_i[0];
        end else if (!w_faulty[1]) begin
            w_lo = data_i[1];
        end else if (!w_faulty[2]) begin
            w_lo = data_i[2];
        end else begin
            w_lo = data_i[0];
        end
        if (w_faulty == 3'b100) begin
            w_hi = data_i[1];
        end else begin
            w_hi = data_i[2];
        end
    end

    // Voting, error classification and counter update gating per mode
    always_comb begin
        w_voted  = w_maj;
        w_det    = 1'b0;
        w_cor    = 1'b0;
        w_unc    = 1'b0;
        w_mism   = 3'b000;
        w_update = 3'b000;
        case (w_mode)
            TMR_FULL: begin
                w_voted = w_maj;
                for (int i = 0; i < 3; i++) begin
                    w_mism[i] = (data_i[i] != w_maj);
                end
                w_det    = |w_mism;
                w_cor    = |w_mism;
                w_update = enable_i & ~w_faulty;
            end
            TMR_DEGRADED: begin
                // Disagreement cannot be attributed to either survivor
                w_voted = w_lo;
                if (w_lo != w_hi) begin
                    w_det = 1'b1;
                    w_unc = 1'b1;
                end else begin
                    w_det = 1'b0;
                    w_unc = 1'b0;
                end
            end
            TMR_FAILED: begin
                w_voted = w_lo;
                w_unc   = 1'b1;
            end
            default: begin
                w_voted = w_lo;
                w_unc   = 1'b1;
            end
        endcase
    end

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        cv32e40p_tmr_err_counter #(
            .CNT_W     (CNT_W),
            .THRESHOLD (THRESHOLD),
            .LEAK      (LEAK)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (clear_i),
            .update_i (w_update[g]),
            .mism_i   (w_mism[g]),
            .count_o  (w_count[g]),
            .faulty_o (w_faulty[g]),
            .event_o  (w_event[g])
        );
    end

    assign voted_o             = w_voted;
    assign err_detected_o      = w_det;
    assign err_corrected_o     = w_cor;
    assign err_uncorrectable_o = w_unc;
    assign faulty_o            = w_faulty;
    assign perf_event_o        = w_event;
    assign mode_o              = w_mode;
    assign count_o             = w_count;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Self-checking bench for cv32e40p_tmr_fault_monitor: directed vector table,
// hand-written corner sequences and random stimulus against a behavioural model.
module tb_cv32e40p_tmr_fault_monitor;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        en;
    logic [2:0][31:0]  din;
    logic              clr;
    logic [31:0]       voted;
    logic              det, cor, unc;
    logic [2:0]        flt, perf;
    logic [1:0]        mode;
    logic [2:0][7:0]   cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    int     m_cnt[3];
    bit [2:0] m_f;
    bit [2:0] m_p;

    typedef struct {
        logic [2:0]  en;
        logic [31:0] d0, d1, d2;
        logic [31:0] voted;
        logic        det, cor, unc;
        logic [2:0]  flt, perf;
        logic [1:0]  mode;
        logic [7:0]  c0, c1, c2;
    } vec_t;

    vec_t tbl[9];

    cv32e40p_tmr_fault_monitor #(
        .WIDTH(32), .CNT_W(8), .THRESHOLD(4), .LEAK(2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (en),
        .data_i              (din),
        .clear_i             (clr),
        .voted_o             (voted),
        .err_detected_o      (det),
        .err_corrected_o     (cor),
        .err_uncorrectable_o (unc),
        .faulty_o            (flt),
        .perf_event_o        (perf),
        .mode_o              (mode),
        .count_o             (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_majority(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) begin
            r[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
        end
        return r;
    endfunction

    function automatic int m_nfaulty();
        return int'(m_f[0]) + int'(m_f[1]) + int'(m_f[2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_f = 3'b000;
        m_p = 3'b000;
    endtask

    // Expected outputs from the model's current state and the applied inputs
    task automatic check_model(input string tag);
        int          nf;
        int          h0, h1;
        logic [31:0] ev;
        logic        edet, ecor, eunc;
        logic [2:0]  mism;
        nf   = m_nfaulty();
        edet = 1'b0; ecor = 1'b0; eunc = 1'b0;
        h0 = -1; h1 = -1;
        if (nf == 0) begin
            ev = m_majority(din[0], din[1], din[2]);
            for (int i = 0; i < 3; i++) mism[i] = (din[i] != ev);
            edet = |mism;
            ecor = |mism;
        end else if (nf == 1) begin
            for (int i = 0; i < 3; i++) begin
                if (!m_f[i]) begin
                    if (h0 < 0) h0 = i;
                    else        h1 = i;
                end
            end
            ev   = din[h0];
            edet = (din[h0] != din[h1]);
            eunc = edet;
        end else begin
            ev = din[0];
            for (int i = 2; i >= 0; i--) if (!m_f[i]) ev = din[i];
            eunc = 1'b1;
        end
        chk({tag, ".voted"}, 64'(voted), 64'(ev));
        chk({tag, ".det"},   64'(det),   64'(edet));
        chk({tag, ".cor"},   64'(cor),   64'(ecor));
        chk({tag, ".unc"},   64'(unc),   64'(eunc));
        chk({tag, ".faulty"}, 64'(flt),  64'(m_f));
        chk({tag, ".perf"},  64'(perf),  64'(m_p));
        chk({tag, ".mode"},  64'(mode),  64'((nf >= 2) ? 2 : nf));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.count%0d", tag, i), 64'(cnt[i]), 64'(m_cnt[i]));
        end
    endtask

    // Next model state from the inputs sampled at a rising edge
    task automatic model_step();
        logic [31:0] mj;
        if (clr) begin
            model_reset();
        end else begin
            m_p = 3'b000;
            if (m_nfaulty() == 0) begin
                mj = m_majority(din[0], din[1], din[2]);
                for (int i = 0; i < 3; i++) begin
                    if (en[i]) begin
                        if (din[i] != mj) m_cnt[i] = (m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1;
                        else              m_cnt[i] = (m_cnt[i] >= 2) ? m_cnt[i] - 2 : 0;
                        if (m_cnt[i] >= 4) begin
                            m_f[i] = 1'b1;
                            m_p[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_cycle(input string tag);
        #2;
        check_model(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_d(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        din[0] = a; din[1] = b; din[2] = c;
    endtask

    initial begin
        // Directed table: reset, single-replica fault, degraded disagreement
        tbl[0] = '{3'b111, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                   1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'b00, 8'd0, 8'd0, 8'd0};
        for (int r = 1; r <= 4; r++) begin
            tbl[r] = '{3'b111, 32'h0000FFFE, 32'h0000FFFF, 32'h0000FFFE, 32'h0000FFFE,
                       1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 8'd0, 8'(r - 1), 8'd0};
        end
        tbl[5] = '{3'b111, 32'h0000FFFE, 32'h0000FFFF, 32'h0000FFFE, 32'h0000FFFE,
                   1'b0, 1'b0, 1'b0, 3'b010, 3'b010, 2'b01, 8'd0, 8'd4, 8'd0};
        tbl[6] = '{3'b111, 32'h00001111, 32'h0000FFFF, 32'h00001111, 32'h00001111,
                   1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 2'b01, 8'd0, 8'd4, 8'd0};
        tbl[7] = '{3'b111, 32'd5, 32'd9, 32'd6, 32'd5,
                   1'b1, 1'b0, 1'b1, 3'b010, 3'b000, 2'b01, 8'd0, 8'd4, 8'd0};
        tbl[8] = tbl[7];

        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 3'b111;
        set_d(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.count", 64'(cnt), 64'd0);
        chk("reset.mode", 64'(mode), 64'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            en = tbl[r].en;
            set_d(tbl[r].d0, tbl[r].d1, tbl[r].d2);
            #2;
            chk($sformatf("tbl%0d.voted", r),  64'(voted), 64'(tbl[r].voted));
            chk($sformatf("tbl%0d.det", r),    64'(det),   64'(tbl[r].det));
            chk($sformatf("tbl%0d.cor", r),    64'(cor),   64'(tbl[r].cor));
            chk($sformatf("tbl%0d.unc", r),    64'(unc),   64'(tbl[r].unc));
            chk($sformatf("tbl%0d.faulty", r), 64'(flt),   64'(tbl[r].flt));
            chk($sformatf("tbl%0d.perf", r),   64'(perf),  64'(tbl[r].perf));
            chk($sformatf("tbl%0d.mode", r),   64'(mode),  64'(tbl[r].mode));
            chk($sformatf("tbl%0d.c0", r),     64'(cnt[0]), 64'(tbl[r].c0));
            chk($sformatf("tbl%0d.c1", r),     64'(cnt[1]), 64'(tbl[r].c1));
            chk($sformatf("tbl%0d.c2", r),     64'(cnt[2]), 64'(tbl[r].c2));
            run_cycle($sformatf("tblm%0d", r));
        end

        // Clear back to full TMR
        clr = 1'b1;
        run_cycle("clr1");
        clr = 1'b0;
        chk("clr1.mode", 64'(mode), 64'd0);
        chk("clr1.faulty", 64'(flt), 64'd0);

        // Leak: three mismatches on replica 2, then masked and clean cycles
        en = 3'b111;
        set_d(32'd7, 32'd7, 32'd8);
        repeat (3) run_cycle("leak.mis");
        chk("leak.cnt3", 64'(cnt[2]), 64'd3);
        en = 3'b011;
        run_cycle("leak.masked");
        chk("leak.masked", 64'(cnt[2]), 64'd3);
        en = 3'b111;
        set_d(32'd7, 32'd7, 32'd7);
        run_cycle("leak.c1");
        chk("leak.cnt1", 64'(cnt[2]), 64'd1);
        run_cycle("leak.c2");
        chk("leak.cnt0", 64'(cnt[2]), 64'd0);
        run_cycle("leak.c3");
        chk("leak.nowrap", 64'(cnt[2]), 64'd0);

        // Simultaneous crossing of replicas 0 and 2
        set_d(32'd1, 32'd0, 32'd0);
        repeat (3) run_cycle("sim.c0");
        en = 3'b110;
        set_d(32'd0, 32'd0, 32'd2);
        repeat (3) run_cycle("sim.c2");
        chk("sim.pre0", 64'(cnt[0]), 64'd3);
        chk("sim.pre2", 64'(cnt[2]), 64'd3);
        en = 3'b111;
        set_d(32'd1, 32'd0, 32'd2);
        run_cycle("sim.cross");
        set_d(32'd11, 32'd22, 32'd33);
        #1;
        chk("sim.faulty", 64'(flt), 64'b101);
        chk("sim.mode", 64'(mode), 64'd2);
        chk("sim.perf", 64'(perf), 64'b101);
        chk("sim.voted", 64'(voted), 64'd22);
        chk("sim.unc", 64'(unc), 64'd1);
        run_cycle("sim.after");
        chk("sim.perf_drop", 64'(perf), 64'b000);

        // Clear out of failed mode, then async reset mid-accumulation
        clr = 1'b1;
        run_cycle("clr2");
        clr = 1'b0;
        chk("clr2.mode", 64'(mode), 64'd0);
        chk("clr2.count", 64'(cnt), 64'd0);
        set_d(32'd1, 32'd0, 32'd0);
        repeat (2) run_cycle("rst.acc");
        chk("rst.pre", 64'(cnt[0]), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("rst.async_count", 64'(cnt), 64'd0);
        chk("rst.async_faulty", 64'(flt), 64'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        run_cycle("rst.after");

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] base;
            base = $urandom;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) din[i] = base ^ (32'd1 << $urandom_range(0, 31));
                else                           din[i] = base;
            end
            en  = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 39) == 0);
            run_cycle("rand");
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
# cv32e40p_tmr_fault_monitor

Parametrised triple-modular-redundancy voter with per-replica permanent-fault tracking for the fault-tolerant cv32e40p execution units. It sits between three replicas of a unit (ALU, MULT, LSU result path) and the downstream pipeline, and produces the voted value plus error flags. It maintains a leaky-bucket error counter per replica and latches a replica as permanently faulty once its counter reaches a threshold. It then reconfigures itself from full TMR, to degraded duplex, to failed.

## Interface
- WIDTH, 32, data width of each replica output
- CNT_W, 8, width of each per-replica error counter
- THRESHOLD, 100, counter value at which a replica is declared faulty; must satisfy 1 <= THRESHOLD <= 2^CNT_W-1 (elaboration assertion)
- LEAK, 2, decrement applied on an enabled, error-free cycle; 0 disables leaking
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- enable_i  in  3  per-replica evaluation enable (replica produced a meaningful result this cycle)
- data_i  in  3xWIDTH  replica outputs, index 0..2
- clear_i  in  1  synchronous clear of all counters and fault flags
- voted_o  out  WIDTH  voted result
- err_detected_o  out  1  disagreement among non-faulty replicas this cycle
- err_corrected_o  out  1  disagreement masked by majority this cycle
- err_uncorrectable_o  out  1  voted_o cannot be trusted (degraded mismatch, or failed mode)
- faulty_o  out  3  latched permanent-fault flag per replica
- perf_event_o  out  3  one-cycle pulse when the matching faulty_o bit rises; feeds the performance counters
- mode_o  out  2  current mode, tmr_mode_e
- count_o  out  3xCNT_W  current counter values (debug/CSR readback)

## Operation
- Mode is derived from popcount(faulty):
  - 0 gives TMR_FULL (2'b00).
  - 1 gives TMR_DEGRADED (2'b01).
  - 2 or more gives TMR_FAILED (2'b10).
- Transitions are monotonic: FULL to DEGRADED to FAILED, or FULL straight to FAILED. The only way back to FULL is clear_i or rst_n.
- TMR_FULL:
  - voted_o is the bitwise majority of the three inputs.
  - mism[i] = (data_i[i] != voted_o).
  - err_detected_o = err_corrected_o = |mism.
  - err_uncorrectable_o = 0.
- TMR_DEGRADED:
  - Let a, b be the healthy replicas, with a < b. voted_o = data_i[a].
  - If data_i[a] != data_i[b]: err_detected_o = 1, err_uncorrectable_o = 1, err_corrected_o = 0.
  - Mismatches cannot be attributed in this mode, so no counter updates.
- TMR_FAILED:
  - voted_o = data_i of the lowest-index non-faulty replica, or data_i[0] if all three are faulty.
  - err_detected_o = err_corrected_o = 0; err_uncorrectable_o = 1.
  - Counters are frozen.
- Counter i updates only in TMR_FULL, with enable_i[i] = 1 and faulty[i] = 0:
  - if mism[i]: cnt <= min(cnt + 1, 2^CNT_W - 1);
  - else: cnt <= max(cnt - LEAK, 0), computed without underflow.
- Fault latch: on an edge where counter i's next value is >= THRESHOLD, faulty[i] <= 1 and perf_event_o[i] <= 1 for exactly one cycle. After that, counter i is frozen at its value.
- Simultaneous crossings: both bits set on the same edge, so the mode jumps FULL to FAILED and both perf_event_o bits pulse together.
- clear_i has priority over counting: it zeroes counters, faulty_o and perf_event_o on the next edge. Counting resumes the cycle after.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- Reset values: count_o = 0, faulty_o = 0, perf_event_o = 0, mode_o = TMR_FULL. The combinational outputs follow data_i under TMR_FULL rules.

## Timing
- voted_o and all err_* outputs are combinational from data_i and the registered faulty vector. There is no added pipeline stage.
- count_o, faulty_o, perf_event_o and mode_o are registered.
- Mismatch in cycle n: count_o reflects it in cycle n+1.
- Threshold crossing caused by cycle n: faulty_o, mode_o and perf_event_o change in cycle n+1, and the voting in cycle n+1 already excludes the replica.
- perf_event_o never stays high for two consecutive cycles for the same bit.

## Structure
- The shared package cv32e40p_pkg holds:
  - typedef enum logic [1:0] tmr_mode_e {TMR_FULL, TMR_DEGRADED, TMR_FAILED};
  - the default constants TMR_THRESHOLD_DEFAULT = 100 and TMR_LEAK_DEFAULT = 2.
- Sub-module cv32e40p_tmr_err_counter (CNT_W, THRESHOLD, LEAK) is instantiated three times in a generate loop:
  - inputs: clk, rst_n, clear_i, update_i, mism_i;
  - outputs: count_o, faulty_o, event_o.
- Majority voting, mode decode and output selection are inline combinational logic in the top module.

## Test plan
Bench parameters: WIDTH=32, CNT_W=8, THRESHOLD=4, LEAK=2.
- Reset: all inputs 0xA5A5A5A5, enable_i=3'b111 → voted_o=0xA5A5A5A5, err_detected_o=0, count_o all 0, mode_o=TMR_FULL.
- Single-replica fault: data_i[1]=0x0000FFFF while the others are 0x0000FFFE, for 4 enabled cycles:
  - err_corrected_o=1 each cycle;
  - count_o[1] goes 1,2,3,4;
  - faulty_o=3'b010, perf_event_o=3'b010 for exactly one cycle, mode_o=TMR_DEGRADED;
  - afterwards voted_o=data_i[0].
- Leak: 3 mismatches on replica 2, then 1 clean enabled cycle → count 3 then 1. A further clean cycle gives 0, not a wrap. With enable_i[2]=0, mismatches leave the count unchanged.
- Degraded disagreement: with replica 1 faulty, data_i[0]=5 and data_i[2]=6 → voted_o=5, err_uncorrectable_o=1, err_corrected_o=0, count_o unchanged.
- Simultaneous crossing: counters 0 and 2 at 3, and both mismatch in the same cycle (data_i = 1, 0, 2) → faulty_o=3'b101, mode_o=TMR_FAILED, perf_event_o=3'b101 for one cycle, voted_o=data_i[1].
- Clear and reset: in TMR_FAILED, assert clear_i for 1 cycle → mode_o=TMR_FULL and count_o all 0. Dropping rst_n mid-accumulation zeroes the counters asynchronously.
